// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and the two-port ALU arbiter: widths, opcode
// encodings, the request bundle and the output-buffer state encoding.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_ADD  = 3'd0;
    localparam logic [2:0] FUNCT3_SLL  = 3'd1;
    localparam logic [2:0] FUNCT3_SLT  = 3'd2;
    localparam logic [2:0] FUNCT3_SLTU = 3'd3;
    localparam logic [2:0] FUNCT3_XOR  = 3'd4;
    localparam logic [2:0] FUNCT3_SR   = 3'd5;
    localparam logic [2:0] FUNCT3_OR   = 3'd6;
    localparam logic [2:0] FUNCT3_AND  = 3'd7;

    localparam logic [6:0] FUNCT7_ALT  = 7'h20;

    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [2:0]      funct3;
        logic [6:0]      funct7;
    } alu_req_t;

    typedef enum logic {
        BUF_EMPTY = 1'b0,
        BUF_FULL  = 1'b1
    } buf_state_e;

endpackage

// File: rtl/alu_arbiter_alu.sv
// Purely combinational integer ALU (RV32I register-register ops).
// The clk pin exists only for interface compatibility and is not used.
module ALU
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic [2:0]      funct3,
    input  logic [6:0]      funct7,
    output logic [XLEN-1:0] Result
);

    logic                   alt;
    logic [4:0]             shamt;
    logic signed [XLEN-1:0] sra;
    logic                   unused_ok;

    assign alt       = (funct7 == FUNCT7_ALT);
    assign shamt     = B[4:0];
    // Kept separate so the arithmetic shift is not turned unsigned by the mux.
    assign sra       = $signed(A) >>> shamt;
    assign unused_ok = ^{clk, B[XLEN-1:5]};

    always_comb begin
        Result = '0;
        case (funct3)
            FUNCT3_ADD:  Result = alt ? (A - B) : (A + B);
            FUNCT3_SLL:  Result = A << shamt;
            FUNCT3_SLT:  Result = {{(XLEN-1){1'b0}}, ($signed(A) < $signed(B))};
            FUNCT3_SLTU: Result = {{(XLEN-1){1'b0}}, (A < B)};
            FUNCT3_XOR:  Result = A ^ B;
            FUNCT3_SR:   Result = alt ? $unsigned(sra) : (A >> shamt);
            FUNCT3_OR:   Result = A | B;
            FUNCT3_AND:  Result = A & B;
            default:     Result = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester front end for a single shared ALU: round-robin (or fixed) grant,
// a single-entry registered result buffer, and result routing to the issuing port.
module alu_arbiter #(
    parameter int XLEN  = 32,
    parameter bit RR_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_a,
    input  logic [XLEN-1:0] req0_b,
    input  logic [2:0]      req0_funct3,
    input  logic [6:0]      req0_funct7,

    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_a,
    input  logic [XLEN-1:0] req1_b,
    input  logic [2:0]      req1_funct3,
    input  logic [6:0]      req1_funct7,

    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_result,

    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_result
);

    import alu_pkg::*;

    // Handshake: a transfer happens on a rising edge where valid && ready are both
    // high; ready may look at valid, valid must never look at ready.

    buf_state_e      state_q, state_d;
    logic [XLEN-1:0] buf_data_q, buf_data_d;
    logic            buf_owner_q, buf_owner_d;
    logic            last_grant_q, last_grant_d;

    logic            buf_full;
    logic            drain;
    logic            can_accept;
    logic            grant;
    logic            accept;
    alu_req_t        alu_req;
    logic [XLEN-1:0] alu_result;

    assign buf_full   = (state_q == BUF_FULL);
    assign drain      = buf_full && (buf_owner_q ? rsp1_ready : rsp0_ready);
    assign can_accept = !buf_full || drain;

    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = RR_EN ? !last_grant_q : 1'b0;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign req0_ready = rst_n && can_accept && req0_valid && !grant;
    assign req1_ready = rst_n && can_accept && req1_valid &&  grant;
    assign accept     = req0_ready || req1_ready;

    always_comb begin
        if (grant) begin
            alu_req = '{a: req1_a, b: req1_b, funct3: req1_funct3, funct7: req1_funct7};
        end else begin
            alu_req = '{a: req0_a, b: req0_b, funct3: req0_funct3, funct7: req0_funct7};
        end
    end

    ALU u_alu (
        .clk    (clk),
        .A      (alu_req.a),
        .B      (alu_req.b),
        .funct3 (alu_req.funct3),
        .funct7 (alu_req.funct7),
        .Result (alu_result)
    );

    always_comb begin
        state_d      = state_q;
        buf_data_d   = buf_data_q;
        buf_owner_d  = buf_owner_q;
        last_grant_d = last_grant_q;
        if (accept) begin
            // Also covers drain+accept: the entry is simply overwritten.
            state_d      = BUF_FULL;
            buf_data_d   = alu_result;
            buf_owner_d  = grant;
            last_grant_d = grant;
        end else if (drain) begin
            state_d = BUF_EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= BUF_EMPTY;
            buf_data_q   <= '0;
            buf_owner_q  <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            buf_data_q   <= buf_data_d;
            buf_owner_q  <= buf_owner_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign rsp0_valid  = buf_full && !buf_owner_q;
    assign rsp1_valid  = buf_full &&  buf_owner_q;
    assign rsp0_result = rsp0_valid ? buf_data_q : '0;
    assign rsp1_result = rsp1_valid ? buf_data_q : '0;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios with literal expectations plus a
// randomized run, both checked every cycle against a transaction-level model.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        r0_v, r1_v, s0_rdy, s1_rdy;
    logic [31:0] r0_a, r0_b, r1_a, r1_b;
    logic [2:0]  r0_f3, r1_f3;
    logic [6:0]  r0_f7, r1_f7;

    logic [1:0]       rdy_rr, vld_rr, rdy_fp, vld_fp;
    logic [1:0][31:0] res_rr, res_fp;

    int n_checks = 0;
    int n_errors = 0;
    bit checking = 0;

    // model state per instance: 0 = round-robin, 1 = fixed priority
    logic        m_have [2];
    logic        m_owner[2];
    logic [31:0] m_val  [2];
    logic        m_last [2];

    alu_arbiter #(.XLEN(32), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_v), .req0_ready(rdy_rr[0]), .req0_a(r0_a), .req0_b(r0_b),
        .req0_funct3(r0_f3), .req0_funct7(r0_f7),
        .req1_valid(r1_v), .req1_ready(rdy_rr[1]), .req1_a(r1_a), .req1_b(r1_b),
        .req1_funct3(r1_f3), .req1_funct7(r1_f7),
        .rsp0_valid(vld_rr[0]), .rsp0_ready(s0_rdy), .rsp0_result(res_rr[0]),
        .rsp1_valid(vld_rr[1]), .rsp1_ready(s1_rdy), .rsp1_result(res_rr[1])
    );

    alu_arbiter #(.XLEN(32), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(r0_v), .req0_ready(rdy_fp[0]), .req0_a(r0_a), .req0_b(r0_b),
        .req0_funct3(r0_f3), .req0_funct7(r0_f7),
        .req1_valid(r1_v), .req1_ready(rdy_fp[1]), .req1_a(r1_a), .req1_b(r1_b),
        .req1_funct3(r1_f3), .req1_funct7(r1_f7),
        .rsp0_valid(vld_fp[0]), .rsp0_ready(s0_rdy), .rsp0_result(res_fp[0]),
        .rsp1_valid(vld_fp[1]), .rsp1_ready(s1_rdy), .rsp1_result(res_fp[1])
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic [6:0] f7);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        case (f3)
            3'd0: return (f7 == 7'h20) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                fill = (f7 == 7'h20 && a[31]) ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a >> sh) | fill;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_have[k]  = 1'b0;
            m_owner[k] = 1'b0;
            m_val[k]   = 32'd0;
            m_last[k]  = 1'b1;
        end
    endtask

    // Compare outputs for one instance, then advance its model across the next edge.
    task automatic check_inst(input int k);
        logic [1:0]       rdy, vld, v, rr, exp_rdy;
        logic [1:0][31:0] res;
        logic             taking, room;
        int               w;
        string            tag;
        tag = (k == 0) ? "rr" : "fp";
        rdy = (k == 0) ? rdy_rr : rdy_fp;
        vld = (k == 0) ? vld_rr : vld_fp;
        res = (k == 0) ? res_rr : res_fp;
        v   = {r1_v, r0_v};
        rr  = {s1_rdy, s0_rdy};
        for (int i = 0; i < 2; i++) begin
            logic ev;
            ev = m_have[k] && (m_owner[k] == i[0]);
            check($sformatf("%s rsp%0d_valid", tag, i), {31'd0, vld[i]}, {31'd0, ev});
            check($sformatf("%s rsp%0d_result", tag, i), res[i], ev ? m_val[k] : 32'd0);
        end
        taking = m_have[k] && rr[m_owner[k]];
        room   = !m_have[k] || taking;
        if (v == 2'b11) w = (k == 0) ? ((m_last[k] == 1'b0) ? 1 : 0) : 0;
        else            w = v[1] ? 1 : 0;
        exp_rdy = 2'b00;
        if (rst_n && room && (v != 2'b00)) exp_rdy[w] = 1'b1;
        check($sformatf("%s req_ready", tag), {30'd0, rdy}, {30'd0, exp_rdy});
        if (!rst_n) begin
            m_have[k] = 1'b0; m_owner[k] = 1'b0; m_val[k] = 32'd0; m_last[k] = 1'b1;
        end else if (exp_rdy != 2'b00) begin
            m_have[k]  = 1'b1;
            m_owner[k] = w[0];
            m_last[k]  = w[0];
            m_val[k]   = (w == 1) ? alu_ref(r1_a, r1_b, r1_f3, r1_f7)
                                  : alu_ref(r0_a, r0_b, r0_f3, r0_f7);
        end else if (taking) begin
            m_have[k] = 1'b0;
        end
    endtask

    // scoreboard compare process
    always @(negedge clk) begin
        if (checking) begin
            check_inst(0);
            check_inst(1);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic [6:0] f7);
        r0_a = a; r0_b = b; r0_f3 = f3; r0_f7 = f7;
    endtask

    task automatic set_req1(input logic [31:0] a, input logic [31:0] b,
                            input logic [2:0] f3, input logic [6:0] f7);
        r1_a = a; r1_b = b; r1_f3 = f3; r1_f7 = f7;
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 3))
            0:       return $urandom;
            1:       return 32'($urandom_range(0, 40));
            2:       return 32'h8000_0000;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0; r0_v = 1'b0; r1_v = 1'b0; s0_rdy = 1'b1; s1_rdy = 1'b1;
        set_req0(0, 0, 0, 0);
        set_req1(0, 0, 0, 0);
        model_reset();
        step();
        checking = 1;
        step();
        check("reset rsp_valid", {30'd0, vld_rr}, 32'd0);
        check("reset rsp0_result", res_rr[0], 32'd0);
        check("reset req_ready", {30'd0, rdy_rr}, 32'd0);
        rst_n = 1'b1;

        // single op: 5 + 3 on port 0
        step();
        r0_v = 1'b1; set_req0(5, 3, 3'd0, 7'h00);
        #1 check("single ready", {31'd0, rdy_rr[0]}, 32'd1);
        step();
        r0_v = 1'b0;
        #1 check("single rsp0_valid", {31'd0, vld_rr[0]}, 32'd1);
        check("single rsp0_result", res_rr[0], 32'd8);
        check("single rsp1_valid", {31'd0, vld_rr[1]}, 32'd0);
        step();

        // round-robin tie after a fresh reset
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        r0_v = 1'b1; set_req0(10, 3, 3'd0, 7'h20);
        r1_v = 1'b1; set_req1(32'hF0, 32'hFF, 3'd4, 7'h00);
        for (int j = 0; j < 5; j++) begin
            #1;
            if (j < 4) begin
                check($sformatf("rr grant %0d", j), {30'd0, rdy_rr}, (j % 2 == 1) ? 32'd2 : 32'd1);
                check($sformatf("fp grant %0d", j), {30'd0, rdy_fp}, 32'd1);
            end
            if (j > 0) begin
                check($sformatf("rr tie valid %0d", j), {31'd0, vld_rr[(j-1)%2]}, 32'd1);
                check($sformatf("rr tie result %0d", j), res_rr[(j-1)%2],
                      ((j-1) % 2 == 1) ? 32'h0000_000F : 32'd7);
                check($sformatf("fp tie result %0d", j), res_fp[0], 32'd7);
            end
            step();
        end
        r0_v = 1'b0; r1_v = 1'b0;
        step();

        // backpressure on port 1 with SRA
        r1_v = 1'b1; set_req1(32'h8000_0000, 4, 3'd5, 7'h20); s1_rdy = 1'b0;
        #1 check("bp accept", {31'd0, rdy_rr[1]}, 32'd1);
        step();
        r1_v = 1'b0; r0_v = 1'b1; set_req0(1, 2, 3'd0, 7'h00);
        for (int j = 0; j < 3; j++) begin
            #1 check("bp rsp1_valid", {31'd0, vld_rr[1]}, 32'd1);
            check("bp rsp1_result", res_rr[1], 32'hF800_0000);
            check("bp req_ready", {30'd0, rdy_rr}, 32'd0);
            step();
        end
        s1_rdy = 1'b1;
        #1 check("bp drain+accept", {30'd0, rdy_rr}, 32'd1);
        step();
        r0_v = 1'b0;
        #1 check("bp new rsp0_result", res_rr[0], 32'd3);
        check("bp rsp1 released", {31'd0, vld_rr[1]}, 32'd0);

        // back-to-back throughput on port 0
        step();
        r0_v = 1'b1; set_req0(32'hFFFF_FFFF, 1, 3'd2, 7'h00);
        step();
        set_req0(32'hFFFF_FFFF, 1, 3'd3, 7'h00);
        #1 check("b2b slt", res_rr[0], 32'd1);
        check("b2b ready", {31'd0, rdy_rr[0]}, 32'd1);
        step();
        set_req0(1, 31, 3'd1, 7'h00);
        #1 check("b2b sltu", res_rr[0], 32'd0);
        check("b2b sltu valid", {31'd0, vld_rr[0]}, 32'd1);
        step();
        r0_v = 1'b0;
        #1 check("b2b sll", res_rr[0], 32'h8000_0000);

        // reset while a result is held
        step();
        s0_rdy = 1'b0; r0_v = 1'b1; set_req0(5, 3, 3'd0, 7'h00);
        step();
        r0_v = 1'b0;
        step();
        #1 check("hold rsp0_result", res_rr[0], 32'd8);
        rst_n = 1'b0; r0_v = 1'b1;
        #1 check("ready in reset", {30'd0, rdy_rr}, 32'd0);
        step();
        rst_n = 1'b1; r0_v = 1'b0;
        #1 check("post-reset rsp0_valid", {31'd0, vld_rr[0]}, 32'd0);
        check("post-reset rsp0_result", res_rr[0], 32'd0);
        r0_v = 1'b1; r1_v = 1'b1; s0_rdy = 1'b1; s1_rdy = 1'b1;
        #1 check("post-reset tie", {30'd0, rdy_rr}, 32'd1);
        step();
        r0_v = 1'b0; r1_v = 1'b0;

        // idle keeps last_grant (port 0 last)
        for (int j = 0; j < 5; j++) begin
            step();
            #1 check("idle rsp_valid", {30'd0, vld_rr}, 32'd0);
        end
        r0_v = 1'b1; r1_v = 1'b1;
        #1 check("idle tie rr", {30'd0, rdy_rr}, 32'd2);
        check("idle tie fp", {30'd0, rdy_fp}, 32'd1);
        step();
        r0_v = 1'b0; r1_v = 1'b0;
        step();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n  = ($urandom_range(0, 99) != 0);
            r0_v   = ($urandom_range(0, 99) < 60);
            r1_v   = ($urandom_range(0, 99) < 60);
            s0_rdy = ($urandom_range(0, 99) < 70);
            s1_rdy = ($urandom_range(0, 99) < 70);
            set_req0(rand_operand(), rand_operand(), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 1) ? 7'h20 : 7'h00);
            set_req1(rand_operand(), rand_operand(), 3'($urandom_range(0, 7)),
                     $urandom_range(0, 1) ? 7'h20 : 7'h00);
        end
        step();
        rst_n = 1'b1; r0_v = 1'b0; r1_v = 1'b0;
        step();
        step();
        checking = 0;

        // final report
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
